// File: rtl/fc_y_wr_pkg.sv
// Shared constants for the FC Y write-back path: RTM geometry, mode encodings, FSM states.
package fc_y_wr_pkg;
  localparam int S         = 8;
  localparam int R         = 4;
  localparam int RTM_DEPTH = 4096;
  localparam int AW        = $clog2(RTM_DEPTH);
  localparam int EW        = S * R * 8;
  localparam int IW        = $clog2(S * R);

  localparam logic Y_MODE_T = 1'b0;
  localparam logic Y_MODE_V = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/fc_y_pack.sv
// Places one captured byte into the entry being assembled and derives the bank enables
// for an entry whose last element sits at index idx.
module fc_y_pack
  import fc_y_wr_pkg::*;
(
  input  logic          mode,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    din,
  input  logic [EW-1:0] pack_cur,
  output logic [EW-1:0] pack_next,
  output logic [S-1:0]  bank_en
);
  logic [IW:0] n;
  assign n = {1'b0, idx} + (IW + 1)'(1);

  genvar gi;
  generate
    for (gi = 0; gi < S * R; gi++) begin : g_byte
      localparam int BANK = gi / R;
      localparam int LANE = gi % R;
      logic sel;
      // T-mode only ever targets lane 0 of bank idx; V-mode fills bytes linearly.
      if (LANE == 0) begin : g_lane0
        assign sel = (mode == Y_MODE_V) ? (idx == IW'(gi)) : (idx == IW'(BANK));
      end else begin : g_lane_n
        assign sel = (mode == Y_MODE_V) && (idx == IW'(gi));
      end
      assign pack_next[gi*8 +: 8] = sel ? din : pack_cur[gi*8 +: 8];
    end

    for (gi = 0; gi < S; gi++) begin : g_bank
      assign bank_en[gi] = (mode == Y_MODE_V) ? (n > (IW + 1)'(gi * R))
                                              : (n > (IW + 1)'(gi));
    end
  endgenerate
endmodule

// File: rtl/fc_y_wr.sv
// FC output write-back: pops int8 results from the Y FIFO, packs them into RTM entries.
// Optional fused ReLU against the zero point when FC_Y_WR_RELU_EN is defined.
module fc_y_wr
  import fc_y_wr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_pulse,
  input  logic [AW-1:0]   y_addr,
  input  logic [15:0]     vec_size_minus_1,
  input  logic            y_mode,
  input  logic [7:0]      yz,
  output logic            y_fifo_rd_en,
  input  logic [7:0]      y_fifo_dout,
  input  logic            y_fifo_empty,
  output logic            rtm_wr_vld,
  output logic [S-1:0]    rtm_wr_en,
  output logic [S*AW-1:0] rtm_wr_addr,
  output logic [EW-1:0]   rtm_wr_din,
  output logic            busy,
  output logic            done
);
  logic [1:0]    state_reg;
  logic [AW-1:0] cur_addr_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [15:0]   size_reg;
  logic          mode_reg;
  logic [7:0]    yz_reg;
  logic [16:0]   pops_reg;
  logic          cap_vld_reg;
  logic [15:0]   cap_cnt_reg;
  logic [IW-1:0] idx_reg;
  logic [EW-1:0] pack_reg;
  logic          last_wr_reg;

  logic [7:0]    cap_byte;
  logic [EW-1:0] pack_next;
  logic [S-1:0]  bank_en;
  logic          entry_end;
  logic          last_elem;
  logic          close_entry;

  assign y_fifo_rd_en = (state_reg == ST_RUN) && !y_fifo_empty
                        && (pops_reg <= {1'b0, size_reg});

`ifdef FC_Y_WR_RELU_EN
  assign cap_byte = ($signed(y_fifo_dout) < $signed(yz_reg)) ? yz_reg : y_fifo_dout;
`else
  logic unused_yz;
  assign unused_yz = ^yz_reg;
  assign cap_byte  = y_fifo_dout;
`endif

  fc_y_pack u_pack (
    .mode      (mode_reg),
    .idx       (idx_reg),
    .din       (cap_byte),
    .pack_cur  (pack_reg),
    .pack_next (pack_next),
    .bank_en   (bank_en)
  );

  assign entry_end   = (mode_reg == Y_MODE_V) ? (idx_reg == IW'(S * R - 1))
                                              : (idx_reg == IW'(S - 1));
  assign last_elem   = (cap_cnt_reg == size_reg);
  assign close_entry = cap_vld_reg && (entry_end || last_elem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cur_addr_reg <= '0;
      wr_addr_reg  <= '0;
      size_reg     <= '0;
      mode_reg     <= Y_MODE_T;
      yz_reg       <= '0;
      pops_reg     <= '0;
      cap_vld_reg  <= 1'b0;
      cap_cnt_reg  <= '0;
      idx_reg      <= '0;
      pack_reg     <= '0;
      last_wr_reg  <= 1'b0;
      rtm_wr_vld   <= 1'b0;
      rtm_wr_en    <= '0;
      rtm_wr_din   <= '0;
    end else begin
      cap_vld_reg <= y_fifo_rd_en;
      rtm_wr_vld  <= 1'b0;
      rtm_wr_en   <= '0;
      rtm_wr_din  <= '0;
      wr_addr_reg <= '0;
      last_wr_reg <= 1'b0;

      if (y_fifo_rd_en)
        pops_reg <= pops_reg + 17'd1;

      // The closing byte goes straight into the write data; the pack reg restarts empty.
      if (cap_vld_reg) begin
        cap_cnt_reg <= cap_cnt_reg + 16'd1;
        if (close_entry) begin
          pack_reg     <= '0;
          idx_reg      <= '0;
          rtm_wr_vld   <= 1'b1;
          rtm_wr_en    <= bank_en;
          rtm_wr_din   <= pack_next;
          wr_addr_reg  <= cur_addr_reg;
          cur_addr_reg <= cur_addr_reg + AW'(1);
          last_wr_reg  <= last_elem;
        end else begin
          pack_reg <= pack_next;
          idx_reg  <= idx_reg + IW'(1);
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (start_pulse) begin
            cur_addr_reg <= y_addr;
            size_reg     <= vec_size_minus_1;
            mode_reg     <= y_mode;
            yz_reg       <= yz;
            pops_reg     <= '0;
            cap_cnt_reg  <= '0;
            idx_reg      <= '0;
            pack_reg     <= '0;
            state_reg    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (y_fifo_rd_en && (pops_reg == {1'b0, size_reg}))
            state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rtm_wr_vld && last_wr_reg)
            state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rtm_wr_addr = {S{wr_addr_reg}};
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
endmodule

// File: tb/tb_fc_y_wr.sv
// Directed bench for fc_y_wr with a behavioural Y FIFO and an RTM write recorder.
module tb_fc_y_wr;
  import fc_y_wr_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_pulse = 1'b0;
  logic [AW-1:0]   y_addr = '0;
  logic [15:0]     vec_size_minus_1 = '0;
  logic            y_mode = 1'b0;
  logic [7:0]      yz = '0;
  logic            y_fifo_rd_en;
  logic [7:0]      y_fifo_dout = '0;
  logic            y_fifo_empty;
  logic            rtm_wr_vld;
  logic [S-1:0]    rtm_wr_en;
  logic [S*AW-1:0] rtm_wr_addr;
  logic [EW-1:0]   rtm_wr_din;
  logic            busy;
  logic            done;

  int checks = 0;
  int failures = 0;

  fc_y_wr dut (
    .clk              (clk),
    .rst              (rst),
    .start_pulse      (start_pulse),
    .y_addr           (y_addr),
    .vec_size_minus_1 (vec_size_minus_1),
    .y_mode           (y_mode),
    .yz               (yz),
    .y_fifo_rd_en     (y_fifo_rd_en),
    .y_fifo_dout      (y_fifo_dout),
    .y_fifo_empty     (y_fifo_empty),
    .rtm_wr_vld       (rtm_wr_vld),
    .rtm_wr_en        (rtm_wr_en),
    .rtm_wr_addr      (rtm_wr_addr),
    .rtm_wr_din       (rtm_wr_din),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // FIFO model: dout valid the cycle after a pop; optional every-other-cycle empty gating.
  logic [7:0] fmem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic flush = 1'b0;
  logic gate_en = 1'b0;
  logic gate_ph = 1'b0;

  assign y_fifo_empty = (rd_ptr == wr_ptr) || (gate_en && gate_ph);

  always @(posedge clk) begin
    gate_ph <= ~gate_ph;
    if (flush)
      rd_ptr <= wr_ptr;
    else if (y_fifo_rd_en && !y_fifo_empty) begin
      y_fifo_dout <= fmem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  int            cyc = 0;
  int            viol = 0;
  int            pop_cyc[$];
  int            done_cyc[$];
  int            w_cyc[$];
  logic [AW-1:0] w_addr[$];
  logic [S-1:0]  w_en[$];
  logic [EW-1:0] w_din[$];
  bit            w_same[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (y_fifo_rd_en && !y_fifo_empty) pop_cyc.push_back(cyc);
    if (y_fifo_rd_en && y_fifo_empty) viol <= viol + 1;
    if (done) done_cyc.push_back(cyc);
    if (rtm_wr_vld) begin
      bit same;
      same = 1'b1;
      for (int b = 1; b < S; b++)
        if (rtm_wr_addr[b*AW +: AW] != rtm_wr_addr[AW-1:0]) same = 1'b0;
      w_cyc.push_back(cyc);
      w_addr.push_back(rtm_wr_addr[AW-1:0]);
      w_en.push_back(rtm_wr_en);
      w_din.push_back(rtm_wr_din);
      w_same.push_back(same);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_rec();
    pop_cyc.delete();
    done_cyc.delete();
    w_cyc.delete();
    w_addr.delete();
    w_en.delete();
    w_din.delete();
    w_same.delete();
    viol = 0;
  endtask

  task automatic start_op(input logic [AW-1:0] a, input logic [15:0] n1,
                          input logic m, input logic [7:0] z);
    tick();
    y_addr = a;
    vec_size_minus_1 = n1;
    y_mode = m;
    yz = z;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout: done seen=%0d required=1", name, ok);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({y_fifo_rd_en, rtm_wr_vld, busy, done} !== 4'b0 || rtm_wr_en !== '0
        || rtm_wr_din !== '0 || rtm_wr_addr !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd_en=%b vld=%b busy=%b done=%b en=%h required all 0",
               y_fifo_rd_en, rtm_wr_vld, busy, done, rtm_wr_en);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_tmode();
    logic [EW-1:0] e0, e1;
    clear_rec();
    for (int i = 0; i < 16; i++) push(8'(i));
    start_op(AW'(10), 16'd15, Y_MODE_T, 8'h00);
    wait_done("tmode");
    e0 = '0;
    e1 = '0;
    for (int k = 0; k < S; k++) begin
      e0[k*R*8 +: 8] = 8'(k);
      e1[k*R*8 +: 8] = 8'(8 + k);
    end
    checks++;
    if (w_addr.size() != 2) begin
      failures++;
      $display("FAIL tmode_writes: got=%0d required=2", w_addr.size());
    end else begin
      checks++;
      if (w_addr[0] !== AW'(10) || w_addr[1] !== AW'(11) || !w_same[0] || !w_same[1]) begin
        failures++;
        $display("FAIL tmode_addr: got=%0d,%0d required=10,11", w_addr[0], w_addr[1]);
      end
      checks++;
      if (w_en[0] !== 8'hFF || w_en[1] !== 8'hFF) begin
        failures++;
        $display("FAIL tmode_en: got=%h,%h required=ff,ff", w_en[0], w_en[1]);
      end
      checks++;
      if (w_din[0] !== e0 || w_din[1] !== e1) begin
        failures++;
        $display("FAIL tmode_din: got0=%h required0=%h", w_din[0], e0);
      end
      checks++;
      if (pop_cyc.size() != 16 || w_cyc[0] - pop_cyc[7] != 2 || w_cyc[1] - pop_cyc[15] != 2) begin
        failures++;
        $display("FAIL tmode_latency: pops=%0d w0=%0d w1=%0d required 16 pops, 2-cycle latency",
                 pop_cyc.size(), w_cyc[0], w_cyc[1]);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != w_cyc[1] + 1) begin
        failures++;
        $display("FAIL tmode_done_cycle: done pulses=%0d required 1 pulse at cycle %0d",
                 done_cyc.size(), w_cyc[1] + 1);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL tmode_busy_after: got=%b required=0", busy);
    end
    $display("tmode: writes=%0d", w_addr.size());
  endtask

  task automatic test_vmode();
    logic [EW-1:0] e0, e1;
    clear_rec();
    for (int i = 0; i < 40; i++) push(8'(8'h40 + i));
    start_op(AW'(20), 16'd39, Y_MODE_V, 8'h00);
    // A second start while busy must be ignored.
    y_addr = AW'(99);
    vec_size_minus_1 = 16'd0;
    y_mode = Y_MODE_T;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    wait_done("vmode");
    e0 = '0;
    e1 = '0;
    for (int i = 0; i < 32; i++) e0[i*8 +: 8] = 8'(8'h40 + i);
    for (int i = 0; i < 8; i++) e1[i*8 +: 8] = 8'(8'h60 + i);
    checks++;
    if (w_addr.size() != 2) begin
      failures++;
      $display("FAIL vmode_writes: got=%0d required=2", w_addr.size());
    end else begin
      checks++;
      if (w_addr[0] !== AW'(20) || w_addr[1] !== AW'(21)) begin
        failures++;
        $display("FAIL vmode_addr: got=%0d,%0d required=20,21", w_addr[0], w_addr[1]);
      end
      checks++;
      if (w_en[0] !== 8'hFF || w_en[1] !== 8'h03) begin
        failures++;
        $display("FAIL vmode_en: got=%h,%h required=ff,03", w_en[0], w_en[1]);
      end
      checks++;
      if (w_din[0] !== e0 || w_din[1] !== e1) begin
        failures++;
        $display("FAIL vmode_din: got1=%h required1=%h", w_din[1], e1);
      end
    end
    checks++;
    if (rd_ptr != wr_ptr) begin
      failures++;
      $display("FAIL vmode_consumed: rd=%0d required=%0d", rd_ptr, wr_ptr);
    end
    $display("vmode: writes=%0d", w_addr.size());
  endtask

  task automatic test_empty_toggle();
    logic [EW-1:0] e0, e1;
    clear_rec();
    gate_en = 1'b1;
    for (int i = 0; i < 64; i++) push(8'(i * 3));
    start_op(AW'(100), 16'd63, Y_MODE_V, 8'h00);
    wait_done("toggle");
    gate_en = 1'b0;
    e0 = '0;
    e1 = '0;
    for (int i = 0; i < 32; i++) begin
      e0[i*8 +: 8] = 8'(i * 3);
      e1[i*8 +: 8] = 8'((i + 32) * 3);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL toggle_rd_en_while_empty: got=%0d required=0", viol);
    end
    checks++;
    if (w_addr.size() != 2) begin
      failures++;
      $display("FAIL toggle_writes: got=%0d required=2", w_addr.size());
    end else begin
      checks++;
      if (w_din[0] !== e0 || w_din[1] !== e1 || w_addr[0] !== AW'(100) || w_addr[1] !== AW'(101)) begin
        failures++;
        $display("FAIL toggle_data: got0=%h required0=%h", w_din[0], e0);
      end
    end
    $display("toggle: writes=%0d", w_addr.size());
  endtask

  task automatic test_wrap();
    clear_rec();
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    start_op(AW'(RTM_DEPTH - 1), 16'd15, Y_MODE_T, 8'h00);
    wait_done("wrap");
    checks++;
    if (w_addr.size() != 2) begin
      failures++;
      $display("FAIL wrap_writes: got=%0d required=2", w_addr.size());
    end else begin
      checks++;
      if (w_addr[0] !== AW'(RTM_DEPTH - 1) || w_addr[1] !== AW'(0)) begin
        failures++;
        $display("FAIL wrap_addr: got=%0d,%0d required=%0d,0", w_addr[0], w_addr[1], RTM_DEPTH - 1);
      end
    end
    $display("wrap: writes=%0d", w_addr.size());
  endtask

  task automatic test_reset_mid_run();
    logic [EW-1:0] e0;
    bit reached;
    clear_rec();
    for (int i = 0; i < 16; i++) push(8'(i));
    start_op(AW'(50), 16'd15, Y_MODE_T, 8'h00);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pop_cyc.size() >= 5) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL midrst_pops_timeout: pops=%0d required>=5", pop_cyc.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({y_fifo_rd_en, rtm_wr_vld, busy, done} !== 4'b0 || rtm_wr_en !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: rd_en=%b vld=%b busy=%b done=%b required all 0",
               y_fifo_rd_en, rtm_wr_vld, busy, done);
    end
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (w_addr.size() != 0 || done_cyc.size() != 0) begin
      failures++;
      $display("FAIL midrst_no_write: writes=%0d dones=%0d required 0,0", w_addr.size(), done_cyc.size());
    end
    clear_rec();
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    start_op(AW'(7), 16'd7, Y_MODE_T, 8'h00);
    wait_done("midrst_restart");
    e0 = '0;
    for (int k = 0; k < S; k++) e0[k*R*8 +: 8] = 8'(8'hA0 + k);
    checks++;
    if (w_addr.size() != 1) begin
      failures++;
      $display("FAIL midrst_restart_writes: got=%0d required=1", w_addr.size());
    end else begin
      checks++;
      if (w_addr[0] !== AW'(7) || w_en[0] !== 8'hFF || w_din[0] !== e0) begin
        failures++;
        $display("FAIL midrst_restart_entry: addr=%0d en=%h din=%h required 7,ff,%h",
                 w_addr[0], w_en[0], w_din[0], e0);
      end
    end
    $display("reset_mid_run: restart writes=%0d", w_addr.size());
  endtask

  task automatic test_relu();
    logic [EW-1:0] e0;
    clear_rec();
    push(8'h80);
    push(8'h04);
    push(8'h05);
    push(8'h7F);
    start_op(AW'(3), 16'd3, Y_MODE_T, 8'h05);
    wait_done("relu");
    e0 = '0;
`ifdef FC_Y_WR_RELU_EN
    e0[0*R*8 +: 8] = 8'h05;
    e0[1*R*8 +: 8] = 8'h05;
    e0[2*R*8 +: 8] = 8'h05;
    e0[3*R*8 +: 8] = 8'h7F;
`else
    e0[0*R*8 +: 8] = 8'h80;
    e0[1*R*8 +: 8] = 8'h04;
    e0[2*R*8 +: 8] = 8'h05;
    e0[3*R*8 +: 8] = 8'h7F;
`endif
    checks++;
    if (w_addr.size() != 1) begin
      failures++;
      $display("FAIL relu_writes: got=%0d required=1", w_addr.size());
    end else begin
      checks++;
      if (w_en[0] !== 8'h0F || w_addr[0] !== AW'(3)) begin
        failures++;
        $display("FAIL relu_partial_en: en=%h addr=%0d required 0f,3", w_en[0], w_addr[0]);
      end
      checks++;
      if (w_din[0] !== e0) begin
        failures++;
        $display("FAIL relu_din: got=%h required=%h", w_din[0], e0);
      end
    end
    $display("relu: writes=%0d", w_addr.size());
  endtask

  initial begin
    test_reset();
    test_tmode();
    test_vmode();
    test_empty_toggle();
    test_wrap();
    test_reset_mid_run();
    test_relu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
